fmap_stream_tx: RTL and testbench

Feature-map stream transmitter. Captures the flattened FP16 output bus of a conv/CSP stage in one cycle and emits it one word per beat over a valid/ready stream, word 0 first. It sits at the output end of a layer block such as the CSP1 chain and feeds the next layer's loader or the host DMA, replacing whole-bus readout. Pixel order within a channel and channel order follow the flat bus index exactly.

---
 rtl/fmap_pkg.sv | 28 ++
 rtl/fmap_pos_cnt.sv | 43 ++++
 rtl/fmap_stream_tx.sv | 113 +++++++++++
 tb/tb_fmap_stream_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
// Shared definitions for feature-map layer blocks: FP16 constants, stream state codes
// and a width helper.
package fmap_pkg;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SEND = 1'b1;

    typedef enum logic {
        StIdle = ST_IDLE,
        StSend = ST_SEND
    } tx_state_e;

    // Ceiling log2 clamped to 1 so the result is always a legal vector width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/fmap_pos_cnt.sv
// Two-level pixel/channel wrap counter: the pixel count runs 0..PIX-1 and each wrap
// advances the channel count 0..K-1.
module fmap_pos_cnt
    import fmap_pkg::*;
#(
    parameter int unsigned PIX = 4,
    parameter int unsigned K   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    output logic [clog2(K)-1:0] chan,
    output logic                last
);

    localparam int unsigned    PW       = clog2(PIX);
    localparam int unsigned    KW       = clog2(K);
    localparam logic [PW-1:0]  PIX_MAX  = PW'(PIX - 1);
    localparam logic [KW-1:0]  CHAN_MAX = KW'(K - 1);

    logic [PW-1:0] r_pix;
    logic [KW-1:0] r_chan;
    logic          w_pix_wrap;

    assign w_pix_wrap = (r_pix == PIX_MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_pix  <= '0;
            r_chan <= '0;
        end else if (inc) begin
            r_pix <= w_pix_wrap ? '0 : r_pix + 1'b1;
            if (w_pix_wrap) begin
                r_chan <= (r_chan == CHAN_MAX) ? '0 : r_chan + 1'b1;
            end
        end
    end

    assign chan = r_chan;
    assign last = w_pix_wrap && (r_chan == CHAN_MAX);

endmodule

// File: rtl/fmap_stream_tx.sv
// Feature-map stream transmitter: captures a flat FP16 frame and emits it word 0 first
// over valid/ready. Define FMAP_TX_CHAN_TAG_EN to add the out_chan channel tag.
module fmap_stream_tx
    import fmap_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned K          = 2,
    parameter int unsigned HO         = 2,
    parameter int unsigned WO         = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [K*HO*WO*DATA_WIDTH-1:0]  in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
`ifdef FMAP_TX_CHAN_TAG_EN
    output logic [clog2(K)-1:0]            out_chan,
`endif
    output logic                           drop_err
);

    localparam int unsigned   N        = K * HO * WO;
    localparam int unsigned   CW       = clog2(N);
    localparam logic [CW-1:0] IDX_LAST = CW'(N - 1);

    tx_state_e               r_state;
    tx_state_e               w_state_next;
    logic [N*DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]           r_idx;
    logic                    r_drop;
    logic                    w_capture;
    logic                    w_beat;
    logic                    w_idx_last;

    assign w_idx_last = (r_idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_capture    = 1'b0;
        w_beat       = 1'b0;
        unique case (r_state)
            StIdle: begin
                in_ready  = 1'b1;
                w_capture = in_valid;
                if (in_valid) begin
                    w_state_next = StSend;
                end
            end
            StSend: begin
                out_valid = 1'b1;
                w_beat    = out_ready;
                if (out_ready && w_idx_last) begin
                    w_state_next = StIdle;
                end
            end
        endcase
    end

    // Shifting in zeros leaves the register cleared once the frame has drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_idx   <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_shift <= in_data;
                r_idx   <= '0;
            end else if (w_beat) begin
                r_shift <= r_shift >> DATA_WIDTH;
                r_idx   <= w_idx_last ? '0 : r_idx + 1'b1;
            end
            if (out_valid && in_valid) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign out_data = r_shift[DATA_WIDTH-1:0];
    assign out_last = out_valid && w_idx_last;
    assign drop_err = r_drop;

`ifdef FMAP_TX_CHAN_TAG_EN
    logic w_pos_last;

    fmap_pos_cnt #(
        .PIX (HO * WO),
        .K   (K)
    ) u_pos_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_beat),
        .clr   (w_capture),
        .chan  (out_chan),
        .last  (w_pos_last)
    );
`endif

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Directed bench for fmap_stream_tx: a per-cycle vector table for the basic and
// backpressure frames, then hand-written drop, reset, back-to-back and tag sequences.
module tb_fmap_stream_tx;

    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [127:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          out_last;
    logic          drop_err;
`ifdef FMAP_TX_CHAN_TAG_EN
    logic [0:0]    out_chan;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fmap_stream_tx #(
        .DATA_WIDTH (16),
        .K          (2),
        .HO         (2),
        .WO         (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
`ifdef FMAP_TX_CHAN_TAG_EN
        .out_chan  (out_chan),
`endif
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_data;
        logic        e_last;
        logic        e_drop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic ordy, input logic e_ir,
                                input logic e_ov, input logic [15:0] e_data,
                                input logic e_last, input logic e_drop);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov;
        v.e_data = e_data; v.e_last = e_last; v.e_drop = e_drop;
        return v;
    endfunction

    function automatic logic [127:0] mk_frame(input logic [15:0] base, input logic ramp);
        logic [127:0] f;
        for (int i = 0; i < NW; i++) begin
            f[i*16 +: 16] = ramp ? base + 16'(i) : base;
        end
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int beats;
        int ph;
        int w;

        in_data = mk_frame(16'h3C00, 1'b1);
        do_reset();

        // Basic frame with out_ready held high.
        vecs.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 0));
        for (int i = 0; i < NW; i++) begin
            vecs.push_back(mk(0, 1, 0, 1, 16'h3C00 + 16'(i), i == NW - 1, 0));
        end
        vecs.push_back(mk(1, 1, 1, 0, 16'h0000, 0, 0));
        // Backpressure: ready 1,0,0 repeating; word w accepted only on ready cycles.
        for (int j = 0; j < 22; j++) begin
            w = (j + 2) / 3;
            vecs.push_back(mk(0, (j % 3) == 0, 0, 1, 16'h3C00 + 16'(w), w == NW - 1, 0));
        end
        vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 0));

        for (int v = 0; v < vecs.size(); v++) begin
            check($sformatf("vec%0d in_ready", v), 32'(in_ready), 32'(vecs[v].e_ir));
            check($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'(vecs[v].e_ov));
            check($sformatf("vec%0d out_data", v), 32'(out_data), 32'(vecs[v].e_data));
            check($sformatf("vec%0d out_last", v), 32'(out_last), 32'(vecs[v].e_last));
            check($sformatf("vec%0d drop_err", v), 32'(drop_err), 32'(vecs[v].e_drop));
            in_valid  = vecs[v].iv;
            out_ready = vecs[v].ordy;
            @(negedge clk);
        end

        // Drop: a second frame offered during beat 3 must be ignored.
        do_reset();
        in_data   = mk_frame(16'h3C00, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < NW; k++) begin
            check($sformatf("drop beat%0d data", k), 32'(out_data), 32'(16'h3C00 + 16'(k)));
            check($sformatf("drop beat%0d last", k), 32'(out_last), 32'(k == NW - 1));
            if (k == 4) check("drop_err after offer", 32'(drop_err), 32'd1);
            if (k == 3) begin
                in_valid = 1'b1;
                in_data  = mk_frame(16'h4000, 1'b0);
            end
            if (k == 4) in_valid = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("drop idle%0d out_valid", k), 32'(out_valid), 32'd0);
            check($sformatf("drop idle%0d drop_err", k), 32'(drop_err), 32'd1);
            @(negedge clk);
        end

        // Reset mid-frame after beat 4, with drop_err already set.
        do_reset();
        in_data   = mk_frame(16'h3C00, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rst beat%0d data", k), 32'(out_data), 32'(16'h3C00 + 16'(k)));
            if (k == 1) in_valid = 1'b1;
            if (k == 2) in_valid = 1'b0;
            @(negedge clk);
        end
        check("rst pre drop_err", 32'(drop_err), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst drop_err", 32'(drop_err), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_last", 32'(out_last), 32'd0);
        reset    = 1'b0;
        in_data  = mk_frame(16'hA5A0, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < NW; k++) begin
            check($sformatf("post-rst beat%0d data", k), 32'(out_data),
                  32'(16'hA5A0 + 16'(k)));
            check($sformatf("post-rst beat%0d last", k), 32'(out_last), 32'(k == NW - 1));
            @(negedge clk);
        end
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        // Back-to-back: in_valid held high, frames every 9 cycles.
        do_reset();
        in_data   = mk_frame(16'h3C00, 1'b1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        beats     = 0;
        for (int t = 0; t < 27; t++) begin
            ph = t % 9;
            check($sformatf("b2b t%0d in_ready", t), 32'(in_ready), 32'(ph == 0));
            check($sformatf("b2b t%0d out_valid", t), 32'(out_valid), 32'(ph != 0));
            if (ph != 0) begin
                check($sformatf("b2b t%0d data", t), 32'(out_data),
                      32'(16'h3C00 + 16'(ph - 1)));
                check($sformatf("b2b t%0d last", t), 32'(out_last), 32'(ph == 8));
            end
            if (out_valid && out_ready) beats++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b beat count", 32'(beats), 32'd24);
        check("b2b drop_err", 32'(drop_err), 32'd1);

`ifdef FMAP_TX_CHAN_TAG_EN
        // Channel tag under alternating stalls, then cleared by reset mid-frame.
        do_reset();
        check("chan reset", 32'(out_chan), 32'd0);
        in_data  = mk_frame(16'h3C00, 1'b1);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            w = c / 2;
            out_ready = (c % 2) == 1;
            check($sformatf("chan c%0d tag", c), 32'(out_chan), 32'(w / 4));
            check($sformatf("chan c%0d data", c), 32'(out_data), 32'(16'h3C00 + 16'(w)));
            @(negedge clk);
        end
        check("chan idle", 32'(out_chan), 32'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("chan mid-frame", 32'(out_chan), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("chan after reset", 32'(out_chan), 32'd0);
        reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
